// File: rtl/sig_filter_scheduler_pkg.sv
// Shared types and constants for the filter-engine scheduler.
package sig_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam logic [1:0] MODE_LP    = 2'd0;
    localparam logic [1:0] MODE_HP    = 2'd1;
    localparam logic [1:0] MODE_BP    = 2'd2;
    localparam logic [1:0] MODE_NOTCH = 2'd3;

    localparam int TO_CNT_W = 8;

    function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
        if (v == {TO_CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(TO_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/sig_filter_scheduler_if.sv
// Channel request/response bus and engine job bus of the scheduler.
interface sig_filter_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*DATA_W-1:0] ch_sample;
    logic [NUM_CH*2-1:0]      ch_mode;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH-1:0]        ch_ack;
    logic [DATA_W-1:0]        result_data;
    logic                     result_err;
    logic                     eng_start;
    logic [DATA_W-1:0]        eng_sample;
    logic [1:0]               eng_mode;
    logic                     eng_done;
    logic [DATA_W-1:0]        eng_result;

    modport master (
        input  ch_req, ch_sample, ch_mode, eng_done, eng_result,
        output ch_gnt, ch_ack, result_data, result_err, eng_start, eng_sample, eng_mode
    );

    modport slave (
        output ch_req, ch_sample, ch_mode, eng_done, eng_result,
        input  ch_gnt, ch_ack, result_data, result_err, eng_start, eng_sample, eng_mode
    );
endinterface

// File: rtl/sig_filter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester above the last winner, wrapping.
module sig_rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);
    // Scan upward from last+1 so the most recent winner ends up lowest priority.
    always_comb begin
        int  c;
        logic hit;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        hit   = 1'b0;
        for (int off = 1; off <= NUM_CH; off++) begin
            c      = (int'(last) + off) % NUM_CH;
            hit    = !valid && req[c];
            gnt[c] = gnt[c] | hit;
            idx    = hit ? IDX_W'(c) : idx;
            valid  = valid | hit;
        end
    end
endmodule

// File: rtl/sig_filter_scheduler.sv
// Round-robin scheduler sharing one filter engine between NUM_CH sample channels,
// with a per-job completion timeout.
module sig_filter_scheduler
    import sig_sched_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    sig_filter_scheduler_if.master   bus,
    output logic                     busy,
    output logic [TO_CNT_W-1:0]      timeout_cnt
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [TO_CNT_W-1:0] TIMER_LAST = TO_CNT_W'(TIMEOUT - 1);

    sched_state_t          state_r;
    logic [IDX_W-1:0]      sel_r;
    logic [NUM_CH-1:0]     sel_oh_r;
    logic [IDX_W-1:0]      rr_last_r;
    logic [TO_CNT_W-1:0]   timer_r;
    logic [TO_CNT_W-1:0]   to_cnt_r;
    logic [NUM_CH-1:0]     gnt_r;
    logic [NUM_CH-1:0]     ack_r;
    logic                  start_r;
    logic                  busy_r;
    logic [DATA_W-1:0]     sample_r;
    logic [1:0]            mode_r;
    logic [DATA_W-1:0]     res_r;
    logic                  err_r;

    logic [NUM_CH-1:0]     pick_oh_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_valid_s;
    logic [DATA_W-1:0]     pick_sample_s;
    logic [1:0]            pick_mode_s;

    sig_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (bus.ch_req),
        .last  (rr_last_r),
        .gnt   (pick_oh_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    assign pick_sample_s = bus.ch_sample[int'(pick_idx_s)*DATA_W +: DATA_W];
    assign pick_mode_s   = bus.ch_mode[int'(pick_idx_s)*2 +: 2];

    // Job sequencer: arbitrate, issue, wait for done or timeout, acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            sel_r     <= '0;
            sel_oh_r  <= '0;
            rr_last_r <= IDX_W'(NUM_CH - 1);
            timer_r   <= '0;
            to_cnt_r  <= '0;
            gnt_r     <= '0;
            ack_r     <= '0;
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
            sample_r  <= '0;
            mode_r    <= 2'd0;
            res_r     <= '0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable && pick_valid_s) begin
                        sel_r    <= pick_idx_s;
                        sel_oh_r <= pick_oh_s;
                        sample_r <= pick_sample_s;
                        mode_r   <= pick_mode_s;
                        gnt_r    <= pick_oh_s;
                        start_r  <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= ISSUE;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                ISSUE: begin
                    gnt_r   <= '0;
                    start_r <= 1'b0;
                    timer_r <= '0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the final timer cycle still counts as success.
                    if (bus.eng_done) begin
                        res_r   <= bus.eng_result;
                        err_r   <= 1'b0;
                        ack_r   <= sel_oh_r;
                        state_r <= RESP;
                    end else if (timer_r == TIMER_LAST) begin
                        res_r    <= '0;
                        err_r    <= 1'b1;
                        to_cnt_r <= sat_inc(to_cnt_r);
                        ack_r    <= sel_oh_r;
                        state_r  <= RESP;
                    end else begin
                        timer_r  <= timer_r + {{(TO_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    ack_r     <= '0;
                    rr_last_r <= sel_r;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    ack_r   <= '0;
                    start_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.ch_gnt      = gnt_r;
    assign bus.ch_ack      = ack_r;
    assign bus.result_data = res_r;
    assign bus.result_err  = err_r;
    assign bus.eng_start   = start_r;
    assign bus.eng_sample  = sample_r;
    assign bus.eng_mode    = mode_r;
    assign busy            = busy_r;
    assign timeout_cnt     = to_cnt_r;

endmodule
